loss_seq: RTL
=============

Name: loss_seq

Overview:
Controller that sequences the output-layer loss/delta datapath (target/activation subtract, activation-derivative LUT, 16x8 multiply, one internal register stage) over all N_OUT output neurons.
- On start, issues neuron indices to the target/pre-activation memories and feeds their read data to the loss datapath.
- Tracks pipeline latency and writes each 16-bit delta into the delta buffer with its index.
- Accumulates a signed running sum of deltas for monitoring.
- Pulses done when the last delta is written.

Parameters:
N_OUT, 10, number of output neurons processed per run (>=1)
ADDR_W, 4, index width; 2^ADDR_W >= N_OUT
RD_LAT, 1, cycles from rd_addr to valid t_in/y_in (synchronous memory read)
LG_LAT, 1, cycles from t/y presented to loss datapath until ph_in valid
SUM_W, 24, width of loss_sum accumulator

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE, no done
rd_en  out  1  read strobe to target and y memories
rd_addr  out  ADDR_W  neuron index being read
t_in  in  8  target value from target memory
y_in  in  12  pre-activation value from y memory
lg_t  out  8  target to loss datapath (= t_in, combinational pass)
lg_y  out  12  pre-activation to loss datapath (= y_in, combinational pass)
ph_in  in  16  delta result from loss datapath
wr_en  out  1  delta buffer write strobe
wr_addr  out  ADDR_W  delta buffer index
wr_data  out  16  delta value (= ph_in when wr_en)
loss_sum  out  SUM_W  signed sum of all deltas of the last run
busy  out  1  high in ISSUE, DRAIN, DONE
done  out  1  one-cycle pulse after final write

Behaviour:
- Reset (async): state=IDLE; rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, busy=0, done=0, loss_sum=0, valid/index pipeline cleared.
- L = RD_LAT+LG_LAT. Pipeline: valid shift register of depth L with an ADDR_W index tag per stage. Stage 0 is loaded with rd_en/rd_addr.
  - wr_en = valid of final stage.
  - wr_addr = tag of final stage.
  - wr_data = ph_in.
- IDLE: start=1 -> ISSUE, idx=0, loss_sum cleared to 0 on the same edge. Otherwise stay.
- ISSUE: rd_en=1, rd_addr=idx each cycle.
  - idx increments per cycle.
  - After issuing idx=N_OUT-1 -> DRAIN.
  - No bubbles: exactly N_OUT consecutive rd_en cycles.
- DRAIN: rd_en=0. Wait until the final-stage valid for index N_OUT-1 has been written, then -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Timing, start sampled at edge E0:
  - rd_en cycles 1..N_OUT.
  - wr_en cycles 1+L..N_OUT+L.
  - done in cycle N_OUT+L+1.
  - busy high cycles 1..N_OUT+L+1.
- Accumulation: on each wr_en cycle, loss_sum <= loss_sum + sign_extend(ph_in) to SUM_W. Wraps modulo 2^SUM_W with no saturation. Value holds after done until next start.
- lg_t/lg_y pass through unconditionally. The loss datapath has no enable; the controller simply ignores its output when the pipeline valid is 0.
- start while not IDLE: ignored (no restart, no effect on counters).
- start in DONE cycle: ignored; the next start is accepted in IDLE.
- abort (any state, priority over start):
  - next state IDLE; valid pipeline cleared, so no further wr_en.
  - no done.
  - loss_sum keeps its partial value.
- abort and start in the same IDLE cycle: stay IDLE.
- Reset mid-run: identical to abort except loss_sum is also cleared.
- N_OUT=1: single rd_en cycle, ISSUE -> DRAIN after one cycle, done at cycle 2+L.
- rd_addr holds its last issued value outside ISSUE. wr_addr holds its last written value when wr_en=0.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, busy=0, no rd_en/wr_en.
- N_OUT=10, L=2, start pulse at E0, ph_in driven by a model returning index*3 with one-cycle loss latency:
  - rd_addr 0..9 in cycles 1..10.
  - wr_en cycles 3..12 with wr_addr 0..9 and wr_data 0,3,..,27.
  - done only in cycle 13; loss_sum=135.
- Negative deltas: ph_in=16'hFFFF for all 10 -> loss_sum = -10 sign-correct (24'hFFFFF6).
- start held high through whole run plus re-pulsed at cycle 5 -> exactly one run, 10 writes, one done pulse. A second start after done gives a new run with loss_sum restarting from 0.
- abort at cycle 6:
  - no wr_en from cycle 7 onward; done never asserts; busy=0 at cycle 7.
  - a subsequent start runs fully.
- rst asserted asynchronously mid-DRAIN -> outputs zero immediately without a clock edge. After release, start gives a clean run with N_OUT=1 parameterization: rd cycle 1, write cycle 3, done cycle 4.

Source files
------------

// File: rtl/loss_seq.sv
`default_nettype none
// ============================================================================
// Module   : loss_seq
// Function : Sequences the output-layer loss/delta datapath over all neurons,
//            writes each delta to the delta buffer and sums the deltas.
// Revision : 1.0
// ============================================================================
module loss_seq #(
    parameter int N_OUT  = 10,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int LG_LAT = 1,
    parameter int SUM_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [7:0]          t_in,
    input  logic [11:0]         y_in,
    output logic [7:0]          lg_t,
    output logic [11:0]         lg_y,
    input  logic [15:0]         ph_in,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [15:0]         wr_data,
    output logic [SUM_W-1:0]    loss_sum,
    output logic                busy,
    output logic                done
);

    localparam int                c_lat  = RD_LAT + LG_LAT;
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_lat-1:0]        r_vld;
    logic [ADDR_W-1:0]       r_tag [c_lat];
    logic [ADDR_W-1:0]       r_rd_addr;
    logic signed [SUM_W-1:0] r_sum;
    logic                    w_rd_en;
    logic                    w_wr_en;
    logic                    w_last_wr;
    logic                    w_launch;

    assign w_wr_en   = r_vld[c_lat-1];
    assign w_last_wr = w_wr_en && (r_tag[c_lat-1] == c_last);
    assign w_launch  = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = 1'b1;
                if (r_rd_addr == c_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_wr) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Read index stops on the last neuron so rd_addr holds it after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else if (w_launch) begin
            r_rd_addr <= '0;
        end else if ((r_state == S_ISSUE) && !abort && (r_rd_addr != c_last)) begin
            r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    // Valid/index pipeline; tags advance only with a valid so wr_addr holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < c_lat; i++) begin
                r_tag[i] <= '0;
            end
        end else if (abort) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_en;
            if (w_rd_en) begin
                r_tag[0] <= r_rd_addr;
            end
            for (int i = 1; i < c_lat; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_tag[i] <= r_tag[i-1];
                end
            end
        end
    end

    // A write landing in the abort cycle still counts toward the partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_launch) begin
            r_sum <= '0;
        end else if (w_wr_en) begin
            r_sum <= r_sum + SUM_W'($signed(ph_in));
        end
    end

    assign rd_en    = w_rd_en;
    assign rd_addr  = r_rd_addr;
    assign lg_t     = t_in;
    assign lg_y     = y_in;
    assign wr_en    = w_wr_en;
    assign wr_addr  = r_tag[c_lat-1];
    assign wr_data  = ph_in;
    assign loss_sum = r_sum;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire
